// File: rtl/mem_port_arbiter_if.sv
// Bundle of IF fetch, MEM load/store and memory-bus signals seen by mem_port_arbiter.
// master = arbiter side, slave = pipeline stages plus memory level.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_ack_o;
   logic              ls_ce_i;
   logic              ls_we_i;
   logic [3:0]        ls_sel_i;
   logic [ADDR_W-1:0] ls_addr_i;
   logic [DATA_W-1:0] ls_wdata_i;
   logic [DATA_W-1:0] ls_rdata_o;
   logic              ls_ack_o;
   logic              stall_req_o;
   logic              bus_req_o;
   logic              bus_we_o;
   logic [3:0]        bus_sel_o;
   logic [ADDR_W-1:0] bus_addr_o;
   logic [DATA_W-1:0] bus_wdata_o;
   logic [DATA_W-1:0] bus_rdata_i;
   logic              bus_ack_i;
   logic              bus_err_o;

   modport master (
      input  if_req_i, if_addr_i, ls_ce_i, ls_we_i, ls_sel_i, ls_addr_i, ls_wdata_i,
             bus_rdata_i, bus_ack_i,
      output if_rdata_o, if_ack_o, ls_rdata_o, ls_ack_o, stall_req_o,
             bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o
   );

   modport slave (
      output if_req_i, if_addr_i, ls_ce_i, ls_we_i, ls_sel_i, ls_addr_i, ls_wdata_i,
             bus_rdata_i, bus_ack_i,
      input  if_rdata_o, if_ack_o, ls_rdata_o, ls_ack_o, stall_req_o,
             bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and load/store,
// with a per-access timeout that acks the requester with zero data and a sticky error.
//
// state  | meaning
// IDLE   | no access in flight, requests sampled here only
// LS_BUS | load/store access on the bus, waiting for bus_ack_i or timeout
// IF_BUS | fetch access on the bus, waiting for bus_ack_i or timeout
// DONE   | one-cycle ack to the served port, then back to IDLE
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TMO    = 255
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.master p
);
   typedef enum logic [1:0] {IDLE, LS_BUS, IF_BUS, DONE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              last_ls_q, last_ls_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [3:0]        bus_sel_q, bus_sel_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              ls_ack_q, ls_ack_d;
   logic              if_ack_q, if_ack_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_v;
   logic              grant_ls;
   logic              tmo_hit;
   logic              finish;

   // LS wins a tie unless it was the last one served
   assign grant_ls = p.ls_ce_i & (~p.if_req_i | ~last_ls_q);
   assign tmo_hit  = (cnt_q == TMO_LAST);
   assign finish   = p.bus_ack_i | tmo_hit;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:           if (p.ls_ce_i | p.if_req_i) state_d = grant_ls ? LS_BUS : IF_BUS;
         LS_BUS, IF_BUS: if (finish) state_d = DONE;
         default:        state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = 8'd0;
      last_ls_d   = last_ls_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      ls_ack_d    = 1'b0;
      if_ack_d    = 1'b0;
      ls_rdata_d  = ls_rdata_q;
      if_rdata_d  = if_rdata_q;
      err_d       = err_q;
      rdata_v     = p.bus_ack_i ? p.bus_rdata_i : '0;
      case (state_q)
         IDLE: begin
            if (grant_ls) begin
               bus_req_d   = 1'b1;
               bus_we_d    = p.ls_we_i;
               bus_sel_d   = p.ls_sel_i;
               bus_addr_d  = p.ls_addr_i;
               bus_wdata_d = p.ls_wdata_i;
               last_ls_d   = 1'b1;
            end else if (p.if_req_i) begin
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_sel_d   = 4'b1111;
               bus_addr_d  = p.if_addr_i;
               bus_wdata_d = '0;
               last_ls_d   = 1'b0;
            end
         end
         LS_BUS, IF_BUS: begin
            cnt_d = cnt_q + 8'd1;
            if (finish) begin
               bus_req_d = 1'b0;
               if (!p.bus_ack_i) err_d = 1'b1;
               if (state_q == LS_BUS) begin
                  ls_ack_d = 1'b1;
                  // a completed store leaves the load data register alone
                  if (!bus_we_q || !p.bus_ack_i) ls_rdata_d = rdata_v;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = rdata_v;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= 8'd0;
         last_ls_q   <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= 4'b0000;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         ls_ack_q    <= 1'b0;
         if_ack_q    <= 1'b0;
         ls_rdata_q  <= '0;
         if_rdata_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         last_ls_q   <= last_ls_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         ls_ack_q    <= ls_ack_d;
         if_ack_q    <= if_ack_d;
         ls_rdata_q  <= ls_rdata_d;
         if_rdata_q  <= if_rdata_d;
         err_q       <= err_d;
      end
   end

   assign p.bus_req_o   = bus_req_q;
   assign p.bus_we_o    = bus_we_q;
   assign p.bus_sel_o   = bus_sel_q;
   assign p.bus_addr_o  = bus_addr_q;
   assign p.bus_wdata_o = bus_wdata_q;
   assign p.ls_ack_o    = ls_ack_q;
   assign p.if_ack_o    = if_ack_q;
   assign p.ls_rdata_o  = ls_rdata_q;
   assign p.if_rdata_o  = if_rdata_q;
   assign p.bus_err_o   = err_q;
   assign p.stall_req_o = (p.ls_ce_i & ~ls_ack_q) | (p.if_req_i & ~if_ack_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with TMO = 4 so the timeout path is short.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_port_arbiter_if m_if ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO(4)) dut (
      .clk (clk),
      .rst (rst),
      .p   (m_if)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m_if.if_req_i    = 1'b0;
      m_if.if_addr_i   = '0;
      m_if.ls_ce_i     = 1'b0;
      m_if.ls_we_i     = 1'b0;
      m_if.ls_sel_i    = 4'b0000;
      m_if.ls_addr_i   = '0;
      m_if.ls_wdata_i  = '0;
      m_if.bus_rdata_i = '0;
      m_if.bus_ack_i   = 1'b0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      n_checks++; if (m_if.bus_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req: got %b want 0", m_if.bus_req_o); end
      n_checks++; if ({m_if.ls_ack_o, m_if.if_ack_o} !== 2'b00) begin n_fail++; $display("FAIL rst_acks: got %b want 00", {m_if.ls_ack_o, m_if.if_ack_o}); end
      n_checks++; if (m_if.bus_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", m_if.bus_err_o); end
      n_checks++; if ({m_if.ls_rdata_o, m_if.if_rdata_o} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {m_if.ls_rdata_o, m_if.if_rdata_o}); end
      n_checks++; if ({m_if.bus_we_o, m_if.bus_sel_o, m_if.bus_addr_o} !== 37'h0) begin n_fail++; $display("FAIL rst_bus_fields: got %h want 0", {m_if.bus_we_o, m_if.bus_sel_o, m_if.bus_addr_o}); end
      n_checks++; if (m_if.stall_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", m_if.stall_req_o); end
      rst = 1'b0;
   endtask

   task automatic test_ls_load();
      m_if.ls_ce_i = 1'b1; m_if.ls_we_i = 1'b0; m_if.ls_sel_i = 4'b1111; m_if.ls_addr_i = 32'h0000_0100;
      #1;
      n_checks++; if (m_if.stall_req_o !== 1'b1) begin n_fail++; $display("FAIL load_stall_wait: got %b want 1", m_if.stall_req_o); end
      tick();
      n_checks++; if ({m_if.bus_req_o, m_if.bus_we_o, m_if.bus_addr_o} !== {1'b1, 1'b0, 32'h0000_0100}) begin
         n_fail++; $display("FAIL load_grant: got req=%b we=%b addr=%h want 1 0 00000100", m_if.bus_req_o, m_if.bus_we_o, m_if.bus_addr_o); end
      tick();
      n_checks++; if ({m_if.bus_req_o, m_if.ls_ack_o} !== 2'b10) begin n_fail++; $display("FAIL load_wait: got req/ack=%b want 10", {m_if.bus_req_o, m_if.ls_ack_o}); end
      m_if.bus_rdata_i = 32'hDEAD_BEEF; m_if.bus_ack_i = 1'b1;
      tick();
      n_checks++; if ({m_if.ls_ack_o, m_if.bus_req_o, m_if.if_ack_o} !== 3'b100) begin n_fail++; $display("FAIL load_ack: got ack/req/ifack=%b want 100", {m_if.ls_ack_o, m_if.bus_req_o, m_if.if_ack_o}); end
      n_checks++; if (m_if.ls_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", m_if.ls_rdata_o); end
      m_if.bus_ack_i = 1'b0; m_if.ls_ce_i = 1'b0; m_if.bus_rdata_i = '0;
      #1;
      n_checks++; if (m_if.stall_req_o !== 1'b0) begin n_fail++; $display("FAIL load_stall_after: got %b want 0", m_if.stall_req_o); end
      tick();
      n_checks++; if ({m_if.ls_ack_o, m_if.ls_rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL load_ack_pulse: got ack=%b rdata=%h want 0 deadbeef", m_if.ls_ack_o, m_if.ls_rdata_o); end
   endtask

   task automatic test_store();
      m_if.ls_ce_i = 1'b1; m_if.ls_we_i = 1'b1; m_if.ls_sel_i = 4'b0010;
      m_if.ls_addr_i = 32'h0000_0400; m_if.ls_wdata_i = 32'h5A5A_5A5A; m_if.bus_rdata_i = 32'h1234_5678;
      tick();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({m_if.bus_req_o, m_if.bus_we_o, m_if.bus_sel_o, m_if.bus_addr_o, m_if.bus_wdata_o} !== {1'b1, 1'b1, 4'b0010, 32'h0000_0400, 32'h5A5A_5A5A}) begin
            n_fail++; $display("FAIL store_fields_%0d: got req=%b we=%b sel=%b addr=%h wdata=%h want 1 1 0010 00000400 5a5a5a5a",
                               i, m_if.bus_req_o, m_if.bus_we_o, m_if.bus_sel_o, m_if.bus_addr_o, m_if.bus_wdata_o);
         end
         m_if.ls_addr_i = 32'h0000_0FFF; m_if.ls_wdata_i = '0; m_if.ls_sel_i = 4'b1111;
         tick();
      end
      m_if.bus_ack_i = 1'b1;
      tick();
      n_checks++; if ({m_if.ls_ack_o, m_if.ls_rdata_o} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL store_ack_rdata: got ack=%b rdata=%h want 1 deadbeef", m_if.ls_ack_o, m_if.ls_rdata_o); end
      m_if.bus_ack_i = 1'b0; m_if.ls_ce_i = 1'b0;
      tick();
   endtask

   task automatic test_both();
      reset_dut();
      m_if.ls_ce_i = 1'b1; m_if.ls_we_i = 1'b1; m_if.ls_sel_i = 4'b0011;
      m_if.ls_addr_i = 32'h0000_0200; m_if.ls_wdata_i = 32'h1111_2222;
      m_if.if_req_i = 1'b1; m_if.if_addr_i = 32'h0000_0300;
      tick();
      n_checks++; if ({m_if.bus_req_o, m_if.bus_we_o, m_if.bus_sel_o, m_if.bus_addr_o} !== {1'b1, 1'b1, 4'b0011, 32'h0000_0200}) begin
         n_fail++; $display("FAIL both_first_ls: got req=%b we=%b sel=%b addr=%h want 1 1 0011 00000200", m_if.bus_req_o, m_if.bus_we_o, m_if.bus_sel_o, m_if.bus_addr_o); end
      m_if.bus_ack_i = 1'b1;
      tick();
      n_checks++; if ({m_if.ls_ack_o, m_if.if_ack_o} !== 2'b10) begin n_fail++; $display("FAIL both_ls_ack: got ls/if=%b want 10", {m_if.ls_ack_o, m_if.if_ack_o}); end
      m_if.bus_ack_i = 1'b0; m_if.ls_ce_i = 1'b0;
      tick();
      n_checks++; if (m_if.bus_req_o !== 1'b0) begin n_fail++; $display("FAIL both_idle_gap: got req=%b want 0", m_if.bus_req_o); end
      tick();
      n_checks++; if ({m_if.bus_req_o, m_if.bus_we_o, m_if.bus_sel_o, m_if.bus_addr_o} !== {1'b1, 1'b0, 4'b1111, 32'h0000_0300}) begin
         n_fail++; $display("FAIL both_then_if: got req=%b we=%b sel=%b addr=%h want 1 0 1111 00000300", m_if.bus_req_o, m_if.bus_we_o, m_if.bus_sel_o, m_if.bus_addr_o); end
      m_if.bus_rdata_i = 32'hCAFE_F00D; m_if.bus_ack_i = 1'b1;
      tick();
      n_checks++; if ({m_if.if_ack_o, m_if.ls_ack_o, m_if.if_rdata_o} !== {2'b10, 32'hCAFE_F00D}) begin
         n_fail++; $display("FAIL both_if_ack: got if/ls=%b rdata=%h want 10 cafef00d", {m_if.if_ack_o, m_if.ls_ack_o}, m_if.if_rdata_o); end
      m_if.bus_ack_i = 1'b0; m_if.if_req_i = 1'b0; m_if.bus_rdata_i = '0;
      tick();
   endtask

   task automatic test_timeout();
      m_if.ls_ce_i = 1'b1; m_if.ls_we_i = 1'b0; m_if.ls_sel_i = 4'b1111;
      m_if.ls_addr_i = 32'h0000_0500; m_if.bus_rdata_i = 32'hFFFF_FFFF;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++; if ({m_if.bus_req_o, m_if.bus_err_o, m_if.ls_ack_o} !== 3'b100) begin
            n_fail++; $display("FAIL tmo_wait_%0d: got req/err/ack=%b want 100", i, {m_if.bus_req_o, m_if.bus_err_o, m_if.ls_ack_o}); end
         tick();
      end
      n_checks++; if ({m_if.bus_req_o, m_if.bus_err_o, m_if.ls_ack_o} !== 3'b011) begin
         n_fail++; $display("FAIL tmo_abort: got req/err/ack=%b want 011", {m_if.bus_req_o, m_if.bus_err_o, m_if.ls_ack_o}); end
      n_checks++; if (m_if.ls_rdata_o !== 32'h0) begin n_fail++; $display("FAIL tmo_rdata: got %h want 0", m_if.ls_rdata_o); end
      m_if.ls_ce_i = 1'b0;
      tick();
      n_checks++; if ({m_if.bus_err_o, m_if.ls_ack_o} !== 2'b10) begin n_fail++; $display("FAIL tmo_sticky: got err/ack=%b want 10", {m_if.bus_err_o, m_if.ls_ack_o}); end
      m_if.bus_ack_i = 1'b1;
      tick();
      m_if.bus_ack_i = 1'b0;
      n_checks++; if ({m_if.bus_req_o, m_if.ls_ack_o, m_if.if_ack_o, m_if.bus_err_o} !== 4'b0001) begin
         n_fail++; $display("FAIL spurious_ack: got req/ls/if/err=%b want 0001", {m_if.bus_req_o, m_if.ls_ack_o, m_if.if_ack_o, m_if.bus_err_o}); end
      tick();
      n_checks++; if ({m_if.ls_ack_o, m_if.if_ack_o} !== 2'b00) begin n_fail++; $display("FAIL spurious_ack_late: got %b want 00", {m_if.ls_ack_o, m_if.if_ack_o}); end
   endtask

   task automatic test_reset_mid();
      m_if.ls_ce_i = 1'b1; m_if.ls_we_i = 1'b0; m_if.ls_addr_i = 32'h0000_0600; m_if.bus_rdata_i = 32'h7777_7777;
      tick();
      n_checks++; if (m_if.bus_req_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got %b want 1", m_if.bus_req_o); end
      rst = 1'b1;
      tick();
      n_checks++; if ({m_if.bus_req_o, m_if.ls_ack_o, m_if.if_ack_o, m_if.bus_err_o} !== 4'b0000) begin
         n_fail++; $display("FAIL rstmid_clear: got req/ls/if/err=%b want 0000", {m_if.bus_req_o, m_if.ls_ack_o, m_if.if_ack_o, m_if.bus_err_o}); end
      rst = 1'b0; m_if.ls_ce_i = 1'b0; m_if.bus_ack_i = 1'b1;
      tick();
      m_if.bus_ack_i = 1'b0;
      n_checks++; if ({m_if.bus_req_o, m_if.ls_ack_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid_late_ack: got req/ack=%b want 00", {m_if.bus_req_o, m_if.ls_ack_o}); end
      tick();
      n_checks++; if ({m_if.ls_ack_o, m_if.ls_rdata_o} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rstmid_after: got ack=%b rdata=%h want 0 0", m_if.ls_ack_o, m_if.ls_rdata_o); end
   endtask

   task automatic test_tmo_edge();
      m_if.ls_ce_i = 1'b1; m_if.ls_we_i = 1'b0; m_if.ls_addr_i = 32'h0000_0700; m_if.bus_rdata_i = 32'h0BAD_C0DE;
      tick();
      tick();
      tick();
      tick();
      n_checks++; if ({m_if.bus_req_o, m_if.ls_ack_o} !== 2'b10) begin n_fail++; $display("FAIL tmoedge_wait: got req/ack=%b want 10", {m_if.bus_req_o, m_if.ls_ack_o}); end
      m_if.bus_ack_i = 1'b1;
      tick();
      n_checks++; if ({m_if.ls_ack_o, m_if.bus_err_o, m_if.ls_rdata_o} !== {2'b10, 32'h0BAD_C0DE}) begin
         n_fail++; $display("FAIL tmoedge_ack_wins: got ack=%b err=%b rdata=%h want 1 0 0badc0de", m_if.ls_ack_o, m_if.bus_err_o, m_if.ls_rdata_o); end
      m_if.bus_ack_i = 1'b0; m_if.ls_ce_i = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] grants;
      logic       prev_req, prev_ls_ack, prev_if_ack;
      int         ngr, nls, nif, ndbl, cyc;
      grants = 4'b0; prev_req = 1'b0; prev_ls_ack = 1'b0; prev_if_ack = 1'b0;
      ngr = 0; nls = 0; nif = 0; ndbl = 0; cyc = 0;
      reset_dut();
      m_if.ls_we_i = 1'b0; m_if.ls_sel_i = 4'b1111; m_if.ls_addr_i = 32'h0000_0A00;
      m_if.if_addr_i = 32'h0000_0B00; m_if.bus_rdata_i = 32'h0000_0042;
      m_if.ls_ce_i = 1'b1; m_if.if_req_i = 1'b1;
      while (!(ngr == 3 && nls + nif == 3) && cyc < 60) begin
         tick();
         cyc++;
         if (m_if.bus_req_o && !prev_req && ngr < 4) begin
            grants[ngr] = (m_if.bus_addr_o == 32'h0000_0A00);
            ngr++;
         end
         if (m_if.ls_ack_o) begin nls++; if (prev_ls_ack) ndbl++; end
         if (m_if.if_ack_o) begin nif++; if (prev_if_ack) ndbl++; end
         prev_req = m_if.bus_req_o; prev_ls_ack = m_if.ls_ack_o; prev_if_ack = m_if.if_ack_o;
         m_if.ls_ce_i   = (ngr < 3) && !m_if.ls_ack_o;
         m_if.if_req_i  = (ngr < 3) && !m_if.if_ack_o;
         m_if.bus_ack_i = m_if.bus_req_o && !m_if.bus_ack_i;
      end
      n_checks++; if (cyc >= 60) begin n_fail++; $display("FAIL b2b_budget: got %0d cycles want completion under 60", cyc); end
      m_if.ls_ce_i = 1'b0; m_if.if_req_i = 1'b0; m_if.bus_ack_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (m_if.bus_req_o && !prev_req) ngr++;
         if (m_if.ls_ack_o) nls++;
         if (m_if.if_ack_o) nif++;
         prev_req = m_if.bus_req_o;
      end
      n_checks++; if (grants[2:0] !== 3'b101) begin n_fail++; $display("FAIL b2b_order: got %b (bit0 first, 1=LS) want 101", grants[2:0]); end
      n_checks++; if (ngr !== 3) begin n_fail++; $display("FAIL b2b_grants: got %0d want 3", ngr); end
      n_checks++; if ({nls[3:0], nif[3:0]} !== 8'h21) begin n_fail++; $display("FAIL b2b_acks: got ls=%0d if=%0d want 2 1", nls, nif); end
      n_checks++; if (ndbl !== 0) begin n_fail++; $display("FAIL b2b_ack_width: got %0d double pulses want 0", ndbl); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_ls_load();
      test_store();
      test_both();
      test_timeout();
      test_reset_mid();
      test_tmo_edge();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
